// File: rtl/ctl_duck_flock_if.sv
// Bus between the game-logic/launch block (master) and the duck flock
// controller (slave); clock and reset travel as plain ports.
interface ctl_duck_flock_if #(
  parameter int N_DUCKS = 2,
  parameter int XW      = 10,
  parameter int SPD_W   = 5
);
  logic                     new_frame;
  logic                     game_start;
  logic [N_DUCKS-1:0]       hit;
  logic [N_DUCKS-1:0]       duck_direction;
  logic [N_DUCKS*SPD_W-1:0] duck_v_spd;
  logic [N_DUCKS*SPD_W-1:0] duck_h_spd;
  logic [N_DUCKS*XW-1:0]    duck_start_x;
  logic [N_DUCKS*XW-1:0]    duck_x;
  logic [N_DUCKS*XW-1:0]    duck_y;
  logic [N_DUCKS-1:0]       duck_show;
  logic [N_DUCKS-1:0]       duck_hit;
  logic [N_DUCKS-1:0]       duck_escaped;
  logic [7:0]               hit_count;
  logic [7:0]               escape_count;

  modport master (
    output new_frame, game_start, hit, duck_direction, duck_v_spd, duck_h_spd, duck_start_x,
    input  duck_x, duck_y, duck_show, duck_hit, duck_escaped, hit_count, escape_count
  );

  modport slave (
    input  new_frame, game_start, hit, duck_direction, duck_v_spd, duck_h_spd, duck_start_x,
    output duck_x, duck_y, duck_show, duck_hit, duck_escaped, hit_count, escape_count
  );
endinterface

// File: rtl/ctl_duck_flock.sv
// Multi-duck flight controller: one launch/fly/hit/escape FSM per duck with
// frame-stepped positions, wall bounces and shared saturating round counters.
module ctl_duck_flock #(
  parameter int N_DUCKS    = 2,
  parameter int XW         = 10,
  parameter int SPD_W      = 5,
  parameter int X_MAX      = 1024,
  parameter int Y_TOP      = 0,
  parameter int Y_FLOOR    = 600,
  parameter int Y_SPAWN    = 768,
  parameter int FALL_SPD   = 8,
  parameter int DEF_V_SPD  = 15,
  parameter int ESC_FRAMES = 300
) (
  input  logic            clk,
  input  logic            rst,
  ctl_duck_flock_if.slave bus
);
  localparam int SW = XW + 2;
  localparam int CW = $clog2(ESC_FRAMES + 1);
  // X_MAX can exceed what the coordinate bus holds; bounce at the lower of the two.
  localparam int X_LIM = (X_MAX > (2**XW) - 1) ? (2**XW) - 1 : X_MAX;

  localparam logic signed [SW-1:0] X_LIM_C   = SW'(X_LIM);
  localparam logic signed [SW-1:0] Y_TOP_C   = SW'(Y_TOP);
  localparam logic signed [SW-1:0] Y_FLOOR_C = SW'(Y_FLOOR);
  localparam logic signed [SW-1:0] FALL_C    = SW'(FALL_SPD);
  localparam logic [XW-1:0]        Y_SPAWN_C = XW'(Y_SPAWN);
  localparam logic [SPD_W-1:0]     DEF_V_C   = SPD_W'(DEF_V_SPD);
  localparam logic [CW-1:0]        ESC_C     = CW'(ESC_FRAMES);

  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_FLY, S_HIT, S_ESC} state_e;

  logic [N_DUCKS-1:0] hit_inc, esc_inc;
  logic [7:0]         hit_cnt_q, hit_cnt_d, esc_cnt_q, esc_cnt_d;

  function automatic logic signed [SW-1:0] widen_pos(input logic [XW-1:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic signed [SW-1:0] widen_spd(input logic [SPD_W-1:0] v);
    return $signed({{(SW-SPD_W){1'b0}}, v});
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [N_DUCKS-1:0] inc);
    logic [8:0] s;
    s = {1'b0, a};
    for (int i = 0; i < N_DUCKS; i++) s = s + {8'd0, inc[i]};
    return (s > 9'd255) ? 8'hFF : s[7:0];
  endfunction

  for (genvar g = 0; g < N_DUCKS; g++) begin : g_duck
    state_e               state_q, state_d;
    logic [XW-1:0]        x_q, x_d, y_q, y_d;
    logic [SPD_W-1:0]     hs_q, hs_d, vs_q, vs_d;
    logic                 dirx_q, dirx_d, up_q, up_d;
    logic [CW-1:0]        fcnt_q, fcnt_d;
    logic                 hl_q, show_q, hitf_q, esc_q, esc_d, edge_w;
    logic [SPD_W-1:0]     v_in, h_in;
    logic signed [SW-1:0] nx, ny, fall_y, esc_y;
    logic                 x_bounce, y_bounce;

    assign v_in   = bus.duck_v_spd[g*SPD_W +: SPD_W];
    assign h_in   = bus.duck_h_spd[g*SPD_W +: SPD_W];
    assign edge_w = bus.hit[g] & ~hl_q;

    assign nx     = dirx_q ? widen_pos(x_q) + widen_spd(hs_q) : widen_pos(x_q) - widen_spd(hs_q);
    assign ny     = up_q   ? widen_pos(y_q) - widen_spd(vs_q) : widen_pos(y_q) + widen_spd(vs_q);
    assign fall_y = widen_pos(y_q) + FALL_C;
    assign esc_y  = widen_pos(y_q) - widen_spd(vs_q);
    // The floor only matters moving down, so a duck spawned below it can climb out.
    assign x_bounce = nx[SW-1] || (nx > X_LIM_C);
    assign y_bounce = up_q ? (ny < Y_TOP_C) : (ny > Y_FLOOR_C);

    always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      dirx_d  = dirx_q;
      up_d    = up_q;
      fcnt_d  = fcnt_q;
      esc_d   = 1'b0;
      if (bus.game_start) begin
        state_d = S_DRAW;
      end else begin
        case (state_q)
          S_IDLE: state_d = S_IDLE;
          S_DRAW: begin
            x_d     = bus.duck_start_x[g*XW +: XW];
            y_d     = Y_SPAWN_C;
            hs_d    = h_in;
            vs_d    = (v_in == '0) ? DEF_V_C : v_in;
            dirx_d  = bus.duck_direction[g];
            up_d    = 1'b1;
            fcnt_d  = '0;
            state_d = S_FLY;
          end
          S_FLY: begin
            if (edge_w) begin
              state_d = S_HIT;
            end else if (bus.new_frame) begin
              if (x_bounce) dirx_d = ~dirx_q;
              else          x_d    = nx[XW-1:0];
              if (y_bounce) up_d = ~up_q;
              else          y_d  = ny[XW-1:0];
              fcnt_d = fcnt_q + 1'b1;
              if (fcnt_d >= ESC_C) state_d = S_ESC;
            end
          end
          S_HIT: begin
            if (bus.new_frame) begin
              y_d = fall_y[XW-1:0];
              if (fall_y > Y_FLOOR_C) state_d = S_DRAW;
            end
          end
          S_ESC: begin
            if (bus.new_frame) begin
              if (esc_y[SW-1]) begin
                esc_d   = 1'b1;
                state_d = S_DRAW;
              end else begin
                y_d = esc_y[XW-1:0];
              end
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        x_q     <= '0;
        y_q     <= '0;
        fcnt_q  <= '0;
        hl_q    <= 1'b0;
        show_q  <= 1'b0;
        hitf_q  <= 1'b0;
        esc_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        x_q     <= x_d;
        y_q     <= y_d;
        fcnt_q  <= fcnt_d;
        hl_q    <= bus.hit[g] & ~bus.game_start;
        show_q  <= (state_d == S_FLY) || (state_d == S_HIT) || (state_d == S_ESC);
        hitf_q  <= (state_d == S_HIT);
        esc_q   <= esc_d;
      end
    end

    // Launch parameters are only read after DRAW has loaded them.
    always_ff @(posedge clk) begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      dirx_q <= dirx_d;
      up_q   <= up_d;
    end

    assign hit_inc[g]                = ~bus.game_start & (state_q == S_FLY) & edge_w;
    assign esc_inc[g]                = esc_d;
    assign bus.duck_x[g*XW +: XW]    = x_q;
    assign bus.duck_y[g*XW +: XW]    = y_q;
    assign bus.duck_show[g]          = show_q;
    assign bus.duck_hit[g]           = hitf_q;
    assign bus.duck_escaped[g]       = esc_q;
  end

  always_comb begin
    hit_cnt_d = sat_add(hit_cnt_q, hit_inc);
    esc_cnt_d = sat_add(esc_cnt_q, esc_inc);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.game_start) begin
      hit_cnt_q <= '0;
      esc_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      esc_cnt_q <= esc_cnt_d;
    end
  end

  assign bus.hit_count    = hit_cnt_q;
  assign bus.escape_count = esc_cnt_q;
endmodule

// File: tb/tb_ctl_duck_flock.sv
// Bench for ctl_duck_flock: directed vector table, hand sequences for bounce,
// hit, escape, restart and saturation, then random traffic against a model.
module tb_ctl_duck_flock;
  localparam int N = 2, XW = 10, SW = 5, ESC = 40;
  localparam int X_MAX = 1024, Y_TOP = 0, Y_FLOOR = 600, Y_SPAWN = 768;
  localparam int FALL = 8, DEFV = 15;
  // Largest x the 10-bit coordinate bus can carry.
  localparam int XLIM = (X_MAX < (2**XW) - 1) ? X_MAX : (2**XW) - 1;
  localparam int M_IDLE = 0, M_LAUNCH = 1, M_FLY = 2, M_FALL = 3, M_FLEE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctl_duck_flock_if #(.N_DUCKS(N), .XW(XW), .SPD_W(SW)) bus();

  ctl_duck_flock #(.N_DUCKS(N), .XW(XW), .SPD_W(SW), .ESC_FRAMES(ESC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int m_mode[N], m_x[N], m_y[N], m_vx[N], m_vy[N], m_frames[N];
  bit m_hl[N], m_esc[N];
  int m_hc, m_ec;

  typedef struct {
    logic       nf;
    logic       gs;
    logic [1:0] hit;
    int         x0;
    int         y0;
    logic       show0;
    logic       hit0;
    int         hc;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    check(name, 64'(act), 64'(exp));
  endtask

  task automatic model_step();
    int nh, ne, nx, ny, v;
    bit edge_h;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_mode[i] = M_IDLE; m_x[i] = 0; m_y[i] = 0; m_hl[i] = 0; m_esc[i] = 0; m_frames[i] = 0;
      end
      m_hc = 0; m_ec = 0;
      return;
    end
    if (bus.game_start) begin
      for (int i = 0; i < N; i++) begin
        m_mode[i] = M_LAUNCH; m_esc[i] = 0; m_hl[i] = 0;
      end
      m_hc = 0; m_ec = 0;
      return;
    end
    nh = 0; ne = 0;
    for (int i = 0; i < N; i++) begin
      edge_h = bus.hit[i] && !m_hl[i];
      m_esc[i] = 0;
      case (m_mode[i])
        M_LAUNCH: begin
          m_x[i] = int'(bus.duck_start_x[i*XW +: XW]);
          m_y[i] = Y_SPAWN;
          v = int'(bus.duck_v_spd[i*SW +: SW]);
          if (v == 0) v = DEFV;
          m_vy[i] = -v;
          m_vx[i] = bus.duck_direction[i] ? int'(bus.duck_h_spd[i*SW +: SW])
                                          : -int'(bus.duck_h_spd[i*SW +: SW]);
          m_frames[i] = 0;
          m_mode[i] = M_FLY;
        end
        M_FLY: begin
          if (edge_h) begin
            m_mode[i] = M_FALL;
            nh++;
          end else if (bus.new_frame) begin
            nx = m_x[i] + m_vx[i];
            if (nx < 0 || nx > XLIM) m_vx[i] = -m_vx[i];
            else m_x[i] = nx;
            ny = m_y[i] + m_vy[i];
            if ((m_vy[i] < 0 && ny < Y_TOP) || (m_vy[i] > 0 && ny > Y_FLOOR)) m_vy[i] = -m_vy[i];
            else m_y[i] = ny;
            m_frames[i]++;
            if (m_frames[i] == ESC) m_mode[i] = M_FLEE;
          end
        end
        M_FALL: begin
          if (bus.new_frame) begin
            m_y[i] += FALL;
            if (m_y[i] > Y_FLOOR) m_mode[i] = M_LAUNCH;
          end
        end
        M_FLEE: begin
          v = (m_vy[i] < 0) ? -m_vy[i] : m_vy[i];
          if (bus.new_frame) begin
            if (m_y[i] - v < 0) begin
              m_esc[i] = 1; ne++; m_mode[i] = M_LAUNCH;
            end else begin
              m_y[i] -= v;
            end
          end
        end
        default: ;
      endcase
      m_hl[i] = bus.hit[i];
    end
    m_hc = (m_hc + nh > 255) ? 255 : m_hc + nh;
    m_ec = (m_ec + ne > 255) ? 255 : m_ec + ne;
  endtask

  task automatic compare_model();
    logic [N*XW-1:0] ex, ey;
    logic [N-1:0]    es, eh, ee;
    for (int i = 0; i < N; i++) begin
      ex[i*XW +: XW] = m_x[i][XW-1:0];
      ey[i*XW +: XW] = m_y[i][XW-1:0];
      es[i] = (m_mode[i] == M_FLY) || (m_mode[i] == M_FALL) || (m_mode[i] == M_FLEE);
      eh[i] = (m_mode[i] == M_FALL);
      ee[i] = m_esc[i];
    end
    check("model", {2'b00, bus.duck_x, bus.duck_y, bus.duck_show, bus.duck_hit, bus.duck_escaped,
                    bus.hit_count, bus.escape_count},
                   {2'b00, ex, ey, es, eh, ee, m_hc[7:0], m_ec[7:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic set_duck(input int i, input bit dir, input int sx, input int v, input int h);
    bus.duck_direction[i]       = dir;
    bus.duck_start_x[i*XW +: XW] = sx[XW-1:0];
    bus.duck_v_spd[i*SW +: SW]   = v[SW-1:0];
    bus.duck_h_spd[i*SW +: SW]   = h[SW-1:0];
  endtask

  task automatic pulse_start();
    bus.game_start = 1'b1;
    tick();
    bus.game_start = 1'b0;
  endtask

  task automatic wait_fly0();
    for (int k = 0; k < 10 && !(bus.duck_show[0] && !bus.duck_hit[0]); k++) tick();
    check_int("wait_fly0", int'(bus.duck_show[0] && !bus.duck_hit[0]), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst = 1'b1;
    bus.new_frame = 1'b0; bus.game_start = 1'b0; bus.hit = '0;
    bus.duck_direction = '0; bus.duck_v_spd = '0; bus.duck_h_spd = '0; bus.duck_start_x = '0;
    tick();
    tick();
    check("reset", {2'b00, bus.duck_x, bus.duck_y, bus.duck_show, bus.duck_hit, bus.duck_escaped,
                    bus.hit_count, bus.escape_count}, 64'd0);
    rst = 1'b0;

    // vector table: launch, move, hit edge with frame, held hit, re-hit
    tbl[0]  = '{1'b0, 1'b1, 2'b00,   0,   0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 2'b00, 100, 768, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 104, 753, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b0, 2'b00, 104, 753, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 108, 738, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0, 2'b01, 108, 738, 1'b1, 1'b1, 1};
    tbl[6]  = '{1'b1, 1'b0, 2'b01, 108, 746, 1'b0, 1'b0, 1};
    tbl[7]  = '{1'b0, 1'b0, 2'b01, 100, 768, 1'b1, 1'b0, 1};
    tbl[8]  = '{1'b1, 1'b0, 2'b01, 104, 753, 1'b1, 1'b0, 1};
    tbl[9]  = '{1'b0, 1'b0, 2'b00, 104, 753, 1'b1, 1'b0, 1};
    tbl[10] = '{1'b0, 1'b0, 2'b01, 104, 753, 1'b1, 1'b1, 2};
    tbl[11] = '{1'b1, 1'b0, 2'b01, 104, 761, 1'b0, 1'b0, 2};
    set_duck(0, 1'b1, 100, 0, 4);
    set_duck(1, 1'b0, 500, 3, 2);
    for (int i = 0; i < 12; i++) begin
      bus.new_frame = tbl[i].nf; bus.game_start = tbl[i].gs; bus.hit = tbl[i].hit;
      tick();
      check($sformatf("vec%0d", i),
            {34'd0, bus.duck_x[XW-1:0], bus.duck_y[XW-1:0], bus.duck_show[0], bus.duck_hit[0], bus.hit_count},
            {34'd0, tbl[i].x0[XW-1:0], tbl[i].y0[XW-1:0], tbl[i].show0, tbl[i].hit0, tbl[i].hc[7:0]});
    end
    bus.new_frame = 1'b0; bus.hit = '0;

    // right-wall bounce: hold then reverse
    set_duck(0, 1'b1, 1022, 0, 4);
    pulse_start();
    tick();
    bus.new_frame = 1'b1;
    tick();
    check_int("bounce_hold", int'(bus.duck_x[XW-1:0]), 1022);
    tick();
    check_int("bounce_back", int'(bus.duck_x[XW-1:0]), 1018);
    bus.new_frame = 1'b0;

    // hit at y=300 with a coincident frame, then fall to the floor
    set_duck(0, 1'b1, 100, 26, 1);
    pulse_start();
    tick();
    bus.new_frame = 1'b1;
    repeat (18) tick();
    check_int("fly_y300", int'(bus.duck_y[XW-1:0]), 300);
    bus.hit = 2'b01;
    tick();
    check_int("hit_nomove", int'(bus.duck_y[XW-1:0]), 300);
    check_int("hit_flag0", int'(bus.duck_hit[0]), 1);
    check_int("hit_flag1", int'(bus.duck_hit[1]), 0);
    check_int("hit_cnt1", int'(bus.hit_count), 1);
    k = 0;
    while (k < 60 && bus.duck_show[0]) begin tick(); k++; end
    check_int("fall_frames", k, 38);
    check_int("fall_y", int'(bus.duck_y[XW-1:0]), 604);
    check_int("held_hit_once", int'(bus.hit_count), 1);
    bus.new_frame = 1'b0; bus.hit = '0;

    // escape after ESC flying frames
    set_duck(0, 1'b1, 100, 10, 1);
    pulse_start();
    tick();
    bus.new_frame = 1'b1;
    k = 0;
    while (k < 200 && !bus.duck_escaped[0]) begin tick(); k++; end
    check_int("esc_frames", k, 77);
    check_int("esc_y", int'(bus.duck_y[XW-1:0]), 8);
    check_int("esc_cnt1", int'(bus.escape_count), 1);
    bus.new_frame = 1'b0;
    tick();
    check_int("esc_pulse_1cyc", int'(bus.duck_escaped[0]), 0);

    // reach 3 hits / 2 escapes, then restart mid-HIT
    bus.new_frame = 1'b1;
    for (int j = 0; j < 400 && bus.escape_count != 8'd2; j++) tick();
    check_int("esc_cnt2", int'(bus.escape_count), 2);
    bus.new_frame = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wait_fly0();
      bus.hit = 2'b01;
      tick();
      bus.hit = 2'b00;
      if (j < 2) begin
        bus.new_frame = 1'b1;
        tick();
        bus.new_frame = 1'b0;
      end
    end
    check_int("pre_gs_hits", int'(bus.hit_count), 3);
    check_int("pre_gs_hitflag", int'(bus.duck_hit[0]), 1);
    pulse_start();
    check_int("gs_hit_cnt", int'(bus.hit_count), 0);
    check_int("gs_esc_cnt", int'(bus.escape_count), 0);
    check_int("gs_show", int'(bus.duck_show), 0);
    check_int("gs_escaped", int'(bus.duck_escaped), 0);

    // both ducks hit together, repeatedly, until the counter saturates
    pulse_start();
    tick();
    for (int j = 0; j < 140; j++) begin
      bus.hit = 2'b11;
      tick();
      if (j == 0) check_int("dual_hit_adds2", int'(bus.hit_count), 2);
      bus.hit = 2'b00; bus.new_frame = 1'b1;
      tick();
      bus.new_frame = 1'b0;
      tick();
    end
    check_int("hit_cnt_sat", int'(bus.hit_count), 255);

    // random traffic
    pulse_start();
    for (int j = 0; j < 4000; j++) begin
      bus.new_frame      = ($urandom_range(0, 2) == 0);
      bus.game_start     = ($urandom_range(0, 299) == 0);
      bus.hit            = bus.hit ^ {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      bus.duck_direction = N'($urandom);
      bus.duck_start_x   = (N*XW)'($urandom);
      bus.duck_v_spd     = (N*SW)'($urandom);
      bus.duck_h_spd     = (N*SW)'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ctl_duck_flock.md
Name: ctl_duck_flock

Overview:
- Controls up to N_DUCKS independent ducks.
- Each duck owns a state machine and an X/Y position updated once per new_frame.
- Extends single-duck control with parametrised bounds and speeds, per-duck hit edge detection, escape timeout and round hit/escape counters.
- Sits between the game-logic/random-launch block and the duck draw stage.

Parameters:
- N_DUCKS, 2, number of independent duck channels (1..4).
- XW, 10, coordinate width in bits.
- SPD_W, 5, speed input width in bits.
- X_MAX, 1024, rightmost legal x.
- Y_TOP, 0, ceiling y while flying.
- Y_FLOOR, 600, floor y; flying bounces here, falling ends here.
- Y_SPAWN, 768, y loaded at launch.
- FALL_SPD, 8, pixels per frame while falling after a hit.
- DEF_V_SPD, 15, vertical speed used when the v_spd input is 0.
- ESC_FRAMES, 300, flying frames before a duck escapes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- new_frame  in  1  one-cycle pulse per video frame
- game_start  in  1  restart pulse; relaunches all ducks
- hit  in  N_DUCKS  per-duck hit level; rising edge counts
- duck_direction  in  N_DUCKS  launch direction per duck: 1=right, 0=left
- duck_v_spd  in  N_DUCKS*SPD_W  per-duck vertical speed, sampled at launch
- duck_h_spd  in  N_DUCKS*SPD_W  per-duck horizontal speed, sampled at launch
- duck_start_x  in  N_DUCKS*XW  per-duck launch x, sampled at launch
- duck_x  out  N_DUCKS*XW  per-duck x
- duck_y  out  N_DUCKS*XW  per-duck y
- duck_show  out  N_DUCKS  duck visible
- duck_hit  out  N_DUCKS  duck in falling (hit) sprite mode
- duck_escaped  out  N_DUCKS  one-cycle pulse when an escape completes
- hit_count  out  8  saturating count of hits this round
- escape_count  out  8  saturating count of escapes this round

Behaviour:
- Reset values:
  - All ducks in IDLE; x=0, y=0.
  - show=0, hit=0, escaped=0.
  - Both counters=0; hit_last=0; frame counters=0.
- Per-duck states:
  - IDLE: waits for game_start, then goes to DRAW.
  - DRAW: one cycle, show=0. Loads x=start_x and y=Y_SPAWN. Latches h_spd, and v_spd (or DEF_V_SPD if v_spd is 0). Sets dir_x=direction, dir_y=up. Clears the fly frame counter. Goes to FLY.
  - FLY: show=1, hit=0. On each new_frame, moves by the latched speeds in dir_x/dir_y and increments the fly frame counter.
  - HIT: show=1, hit=1. On each new_frame, y += FALL_SPD; x held. When y > Y_FLOOR, goes to DRAW.
  - ESCAPE: show=1, hit=0. On each new_frame, y -= v_spd; x held. When the next y would be below 0, pulses escaped for 1 cycle, increments escape_count and goes to DRAW.
- Bounce rule in FLY: compute next x/y at XW+1 bits.
  - x: if next x > X_MAX or underflows, hold x for that frame and flip dir_x.
  - y: if next y < Y_TOP (underflow) or > Y_FLOOR, hold y and flip dir_y.
  - Both axes are evaluated independently in the same frame.
  - Flying up from Y_SPAWN > Y_FLOOR is legal; the floor check applies only when moving down.
- Hit: rising edge of hit[i] (hit & ~hit_last) in FLY goes to HIT next cycle and increments hit_count.
  - Edges in DRAW, HIT, ESCAPE or IDLE are ignored.
  - hit_last is cleared on rst or game_start.
- Escape: when the fly frame counter reaches ESC_FRAMES on a new_frame, go to ESCAPE. A hit edge in the same cycle wins (go to HIT).
- Simultaneous events:
  - Hit edge and new_frame together: go to HIT, no FLY movement that cycle.
  - game_start overrides everything: all ducks go to DRAW next cycle, counters and hit_last cleared, pending escaped pulses suppressed.
- Counters saturate at 255. Two ducks hit in the same cycle add 2.
- Latency: outputs are registered. Positions change the cycle after new_frame; show/hit follow state the cycle after the transition.
- Ducks are fully independent; no channel affects another except through the shared counters.

Test Plan:
- rst, game_start, direction=1, start_x=100, v_spd=0, h_spd=4 -> DRAW then FLY. After 1 new_frame: x=104, y=753, show=1.
- x=1022, dir right, h_spd=4, new_frame -> x holds 1022, dir_x flips. Next frame x=1018.
- Duck 0 hit rising edge coincident with new_frame at y=300 -> no move that frame. hit=1, hit_count=1. y += 8 per frame; DRAW after y > 600.
- Hit held high across 3 frames -> hit_count increments once only. Duck 1 is unaffected.
- ESC_FRAMES=4, no hits -> ESCAPE after 4 frames. y decreases to below 0, then escaped[0] pulses 1 cycle and escape_count=1.
- game_start mid-HIT with counters at 3/2 -> all ducks go to DRAW next cycle, counters=0, no escaped pulse.
